timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
//  Command-driven front end for the timer bank. Accepts START/STOP/WAIT
//  commands from the microcode sequencer on a valid/ready handshake and
//  drives the bank's timer_ld, timer_sel and timer_mem_adr. Consumes
//  timer_done into sticky per-timer flags. WAIT commands stall the command
//  stream until the addressed timer expires.
// PARAMETERS
//  NUM_TIMERS         1  timers in the bank; width of ld/sel/done vectors
//  TIMER_IDX_WIDTH    1  width of cmd_timer; must be >= $clog2(NUM_TIMERS)
//  TIM_MEM_ADR_WIDTH  1  width of the timer preset-memory address
// PORTS
//  clk            in   1    clock
//  rst            in   1    reset, asynchronous, active-high
//  cmd_valid      in   1    command present
//  cmd_ready      out  1    command accepted when cmd_valid && cmd_ready
//  cmd_op         in   2    00 STOP, 01 START, 10 WAIT, 11 START_WAIT
//  cmd_timer      in   TIMER_IDX_WIDTH     target timer index
//  cmd_adr        in   TIM_MEM_ADR_WIDTH   preset address (START ops only)
//  tim_ready      in   1    timer bank preset memory loaded
//  timer_done     in   NUM_TIMERS          from timer bank
//  timer_ld       out  NUM_TIMERS          one-hot load strobe to bank
//  timer_sel      out  NUM_TIMERS          run/enable per timer to bank
//  timer_mem_adr  out  TIM_MEM_ADR_WIDTH   preset address to bank
//  done_flags     out  NUM_TIMERS          sticky expiry flags
//  busy           out  1    state != IDLE
//  err            out  1    one-cycle pulse: rejected command
// BEHAVIOUR
//  - Reset: all outputs 0 asynchronously; state IDLE; cmd_ready=0 while rst.
//  - All outputs are registered except cmd_ready and busy, which decode
//    the state register.
//  - FSM states: IDLE, LOAD, WAIT.
//  - cmd_ready = (state==IDLE) && tim_ready && !rst.
//  - Rejects (checked in priority order; state stays IDLE; err=1 for the next cycle):
//    * cmd_timer >= NUM_TIMERS: command dropped; no other output changes.
//    * WAIT on a timer with timer_sel=0 and done_flag=0: rejected; prevents deadlock.
//  - START / START_WAIT accept (i = cmd_timer):
//    * registers timer_ld = one-hot(i), sets timer_sel[i]=1,
//      timer_mem_adr=cmd_adr, clears done_flags[i]; goes to LOAD.
//    * LOAD lasts exactly 1 cycle with ld high; ld returns to 0 on exit.
//    * START: LOAD -> IDLE. START_WAIT: LOAD -> WAIT.
//    * timer_mem_adr holds its last value until the next START.
//  - STOP accept: timer_sel[i]=0 and done_flags[i]=0 at the next edge;
//    the count freezes in the bank; state stays IDLE.
//  - WAIT accept: if done_flags[i]==1, the command completes immediately
//    (stay IDLE); otherwise go to WAIT.
//  - WAIT -> IDLE on the first cycle with timer_done[i] && !timer_ld[i];
//    the flag sets on the same edge. Latched index held in a register.
//  - done_flags[j] sets on timer_done[j] && timer_sel[j] && !timer_ld[j].
//    Clear (START/STOP on j) wins over set in the same cycle.
//    Flags for other timers update in every state.
//  - A preset of 0 expires in the cycle immediately after LOAD.
//  - tim_ready dropping mid-WAIT does not abort WAIT.
//  - rst mid-LOAD or mid-WAIT aborts immediately; no partial strobe survives.
// STRUCTURE
//  - timer_pkg: typedef enum logic[1:0] tseq_op_e {OP_STOP, OP_START,
//    OP_WAIT, OP_START_WAIT}; typedef enum tseq_state_e {S_IDLE, S_LOAD,
//    S_WAIT}. The package is shared with the microcode assembler tables.
//  - No sub-module. Single always_ff for FSM and registers; cmd_ready/busy decode.
// TESTING  (bench instantiates timer bank; NUM_TIMERS=2, TIMER_WIDTH=8,
//           presets mem[3]=5, mem[4]=0, tim_ready forced high unless noted)
//  1 START t0 adr3 -> ld=01 for 1 cycle, sel[0]=1; done[0] 5 cycles after LOAD; flag[0] next edge
//  2 START_WAIT t1 adr4 -> LOAD, then WAIT exits next cycle; cmd_ready high 3 cycles after accept
//  3 WAIT t1 with sel[1]=0, flag=0 -> err pulse 1 cycle, busy stays 0
//  4 cmd_timer=2 (any op) -> err pulse; ld, sel, adr, flags unchanged
//  5 START t0 adr3, STOP t0 after 2 cycles -> sel[0]=0, count frozen at 3, flag 0; WAIT t0 -> err
//  6 START_WAIT t0 adr3, rst mid-WAIT -> all outputs 0 async; cmd_ready=0 during tim_ready=0

Source files
------------

// File: rtl/timer_sequencer_pkg.sv
// Shared opcode and state encodings for the timer sequencer and the microcode assembler tables.
// Latency: n/a (types only).
// Backpressure: n/a.
package timer_sequencer_pkg;

    // Command opcodes as the microcode sequencer encodes them.
    typedef enum logic [1:0] {
        OP_STOP       = 2'b00,
        OP_START      = 2'b01,
        OP_WAIT       = 2'b10,
        OP_START_WAIT = 2'b11
    } tseq_op_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_WAIT = 2'b10
    } tseq_state_e;

endpackage

// File: rtl/timer_sequencer_if.sv
// Command channel from the microcode sequencer into the timer sequencer.
// Latency: n/a (wires only).
// Backpressure: a command transfers when cmd_valid && cmd_ready.
interface timer_sequencer_if #(
    parameter int TIMER_IDX_WIDTH   = 1,
    parameter int TIM_MEM_ADR_WIDTH = 1
) ();
    import timer_sequencer_pkg::*;

    logic                         cmd_valid;
    logic                         cmd_ready;
    tseq_op_e                     cmd_op;
    logic [TIMER_IDX_WIDTH-1:0]   cmd_timer;
    logic [TIM_MEM_ADR_WIDTH-1:0] cmd_adr;

    modport master (output cmd_valid, output cmd_op, output cmd_timer, output cmd_adr,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_timer, input  cmd_adr,
                    output cmd_ready);
endinterface

// File: rtl/timer_sequencer.sv
// Command front end for the timer bank: START/STOP/WAIT drive ld/sel/adr, done pulses feed sticky flags.
// Latency: outputs registered, 1 cycle after accept; LOAD lasts 1 cycle; WAIT stalls until the timer expires.
// Backpressure: cmd_ready only in IDLE with tim_ready high and reset released.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int NUM_TIMERS        = 1,
    parameter int TIMER_IDX_WIDTH   = 1,
    parameter int TIM_MEM_ADR_WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    timer_sequencer_if.slave             cmd,
    input  logic                         tim_ready,
    input  logic [NUM_TIMERS-1:0]        timer_done,
    output logic [NUM_TIMERS-1:0]        timer_ld,
    output logic [NUM_TIMERS-1:0]        timer_sel,
    output logic [TIM_MEM_ADR_WIDTH-1:0] timer_mem_adr,
    output logic [NUM_TIMERS-1:0]        done_flags,
    output logic                         busy,
    output logic                         err
);

    tseq_state_e                  state_q, state_d;
    logic [NUM_TIMERS-1:0]        ld_q, ld_d;
    logic [NUM_TIMERS-1:0]        sel_q, sel_d;
    logic [NUM_TIMERS-1:0]        flags_q, flags_d;
    logic [TIM_MEM_ADR_WIDTH-1:0] adr_q, adr_d;
    logic                         err_q, err_d;
    logic [TIMER_IDX_WIDTH-1:0]   wait_idx_q, wait_idx_d;
    logic                         then_wait_q, then_wait_d;

    logic                  accept;
    logic                  idx_ok;
    logic                  sel_hit;
    logic                  flag_hit;
    logic                  wait_hit;
    logic [NUM_TIMERS-1:0] cmd_oh;
    logic [NUM_TIMERS-1:0] wait_oh;
    logic [NUM_TIMERS-1:0] flag_set;

    assign cmd.cmd_ready = (state_q == S_IDLE) && tim_ready && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign idx_ok        = int'(cmd.cmd_timer) < NUM_TIMERS;
    // Out-of-range indices map to an empty mask so they can never touch a timer.
    assign cmd_oh        = idx_ok ? (NUM_TIMERS'(1) << cmd.cmd_timer) : '0;
    assign wait_oh       = NUM_TIMERS'(1) << wait_idx_q;
    assign sel_hit       = |(sel_q & cmd_oh);
    assign flag_hit      = |(flags_q & cmd_oh);
    // A done seen while the same timer is being loaded belongs to the old run; ignore it.
    assign flag_set      = timer_done & sel_q & ~ld_q;
    assign wait_hit      = |(timer_done & wait_oh & ~ld_q);

    // State and datapath registers; reset clears every registered output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ld_q        <= '0;
            sel_q       <= '0;
            flags_q     <= '0;
            adr_q       <= '0;
            err_q       <= 1'b0;
            wait_idx_q  <= '0;
            then_wait_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            sel_q       <= sel_d;
            flags_q     <= flags_d;
            adr_q       <= adr_d;
            err_q       <= err_d;
            wait_idx_q  <= wait_idx_d;
            then_wait_q <= then_wait_d;
        end
    end

    // Next-state decode: START ops pass through LOAD, WAIT parks until the latched timer fires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && idx_ok) begin
                    case (cmd.cmd_op)
                        OP_START, OP_START_WAIT: state_d = S_LOAD;
                        OP_WAIT:                 if (!flag_hit && sel_hit) state_d = S_WAIT;
                        default:                 state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD:  state_d = then_wait_q ? S_WAIT : S_IDLE;
            S_WAIT:  if (wait_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register updates for strobes, enables, address, flags and the reject pulse.
    always_comb begin
        ld_d        = '0;
        sel_d       = sel_q;
        adr_d       = adr_q;
        flags_d     = flags_q | flag_set;
        err_d       = 1'b0;
        wait_idx_d  = wait_idx_q;
        then_wait_d = then_wait_q;
        if (accept) begin
            if (!idx_ok) begin
                err_d = 1'b1;
            end else begin
                case (cmd.cmd_op)
                    OP_START, OP_START_WAIT: begin
                        ld_d        = cmd_oh;
                        sel_d       = sel_q | cmd_oh;
                        adr_d       = cmd.cmd_adr;
                        flags_d     = flags_d & ~cmd_oh;
                        wait_idx_d  = cmd.cmd_timer;
                        then_wait_d = (cmd.cmd_op == OP_START_WAIT);
                    end
                    OP_STOP: begin
                        sel_d   = sel_q & ~cmd_oh;
                        flags_d = flags_d & ~cmd_oh;
                    end
                    OP_WAIT: begin
                        // Waiting on a stopped, unexpired timer would never finish.
                        if (!sel_hit && !flag_hit) err_d = 1'b1;
                        else                       wait_idx_d = cmd.cmd_timer;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign timer_ld      = ld_q;
    assign timer_sel     = sel_q;
    assign timer_mem_adr = adr_q;
    assign done_flags    = flags_q;
    assign err           = err_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench: timer_sequencer driving a small behavioural timer bank.
// Latency: n/a.
// Backpressure: commands are only presented while cmd_ready is expected high.
module tb_timer_sequencer;
    import timer_sequencer_pkg::*;

    localparam int NT = 2;
    localparam int IW = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tim_ready;
    logic [NT-1:0] timer_done;
    logic [NT-1:0] timer_ld;
    logic [NT-1:0] timer_sel;
    logic [AW-1:0] timer_mem_adr;
    logic [NT-1:0] done_flags;
    logic          busy;
    logic          err;

    int checks = 0;
    int passes = 0;

    timer_sequencer_if #(.TIMER_IDX_WIDTH(IW), .TIM_MEM_ADR_WIDTH(AW)) cmd_if ();

    timer_sequencer #(
        .NUM_TIMERS       (NT),
        .TIMER_IDX_WIDTH  (IW),
        .TIM_MEM_ADR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .tim_ready    (tim_ready),
        .timer_done   (timer_done),
        .timer_ld     (timer_ld),
        .timer_sel    (timer_sel),
        .timer_mem_adr(timer_mem_adr),
        .done_flags   (done_flags),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Timer bank: load preset on ld, count down while selected, one done pulse when the count runs out.
    logic [7:0]    mem [8];
    logic [7:0]    cnt [NT];
    logic [NT-1:0] fired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NT; j++) cnt[j] <= 8'd0;
            fired <= '0;
        end else begin
            for (int j = 0; j < NT; j++) begin
                if (timer_ld[j]) begin
                    cnt[j]   <= mem[timer_mem_adr];
                    fired[j] <= 1'b0;
                end else if (timer_sel[j]) begin
                    if (cnt[j] != 8'd0) cnt[j] <= cnt[j] - 8'd1;
                    if (timer_done[j])  fired[j] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        timer_done = '0;
        for (int j = 0; j < NT; j++)
            timer_done[j] = timer_sel[j] && !timer_ld[j] && !fired[j] && (cnt[j] <= 8'd1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input tseq_op_e op, input logic [IW-1:0] t, input logic [AW-1:0] a);
        cmd_if.cmd_op    = op;
        cmd_if.cmd_timer = t;
        cmd_if.cmd_adr   = a;
        cmd_if.cmd_valid = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mem[k] = 8'd0;
        mem[3] = 8'd5;
        mem[4] = 8'd0;
        tim_ready        = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_STOP;
        cmd_if.cmd_timer = '0;
        cmd_if.cmd_adr   = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_ready", 32'(cmd_if.cmd_ready), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_ld",    32'(timer_ld), 0);
        check("rst_sel",   32'(timer_sel), 0);
        check("rst_flags", 32'(done_flags), 0);
        check("rst_err",   32'(err), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(cmd_if.cmd_ready), 1);

        // 1: START t0 adr3, preset 5
        send(OP_START, 2'd0, 3'd3);
        check("t1_ld",    32'(timer_ld), 32'h1);
        check("t1_sel",   32'(timer_sel), 32'h1);
        check("t1_adr",   32'(timer_mem_adr), 3);
        check("t1_busy",  32'(busy), 1);
        check("t1_ready", 32'(cmd_if.cmd_ready), 0);
        tick();
        check("t1_ld_off", 32'(timer_ld), 0);
        check("t1_idle",   32'(busy), 0);
        check("t1_done_early", 32'(timer_done), 0);
        tick(); tick(); tick(); tick();
        check("t1_done5",   32'(timer_done), 32'h1);
        check("t1_flag_pre", 32'(done_flags), 0);
        tick();
        check("t1_flag",    32'(done_flags), 32'h1);

        // WAIT on a timer whose flag is already set completes in IDLE
        send(OP_WAIT, 2'd0, 3'd0);
        check("wflag_busy", 32'(busy), 0);
        check("wflag_err",  32'(err), 0);

        // 2: START_WAIT t1 adr4, preset 0
        send(OP_START_WAIT, 2'd1, 3'd4);
        check("t2_ld",   32'(timer_ld), 32'h2);
        check("t2_sel",  32'(timer_sel), 32'h3);
        check("t2_adr",  32'(timer_mem_adr), 4);
        tick();
        check("t2_wait_busy",  32'(busy), 1);
        check("t2_wait_ready", 32'(cmd_if.cmd_ready), 0);
        check("t2_done",       32'(timer_done), 32'h2);
        tick();
        check("t2_ready3", 32'(cmd_if.cmd_ready), 1);
        check("t2_flags",  32'(done_flags), 32'h3);

        // 3: STOP t1 then WAIT t1 is rejected
        send(OP_STOP, 2'd1, 3'd0);
        check("t3_sel",   32'(timer_sel), 32'h1);
        check("t3_flags", 32'(done_flags), 32'h1);
        send(OP_WAIT, 2'd1, 3'd0);
        check("t3_err",  32'(err), 1);
        check("t3_busy", 32'(busy), 0);
        tick();
        check("t3_err_off", 32'(err), 0);

        // 4: out-of-range timer index
        send(OP_START, 2'd2, 3'd5);
        check("t4_err",   32'(err), 1);
        check("t4_ld",    32'(timer_ld), 0);
        check("t4_sel",   32'(timer_sel), 32'h1);
        check("t4_adr",   32'(timer_mem_adr), 4);
        check("t4_flags", 32'(done_flags), 32'h1);
        check("t4_busy",  32'(busy), 0);
        tick();
        check("t4_err_off", 32'(err), 0);

        // 5: START t0, STOP two cycles later freezes the count at 3
        send(OP_START, 2'd0, 3'd3);
        check("t5_flag_clr", 32'(done_flags), 0);
        tick();
        tick();
        send(OP_STOP, 2'd0, 3'd0);
        check("t5_sel",    32'(timer_sel), 0);
        check("t5_cnt",    32'(cnt[0]), 3);
        tick(); tick(); tick();
        check("t5_frozen", 32'(cnt[0]), 3);
        check("t5_flags",  32'(done_flags), 0);
        check("t5_nodone", 32'(timer_done), 0);
        send(OP_WAIT, 2'd0, 3'd0);
        check("t5_wait_err", 32'(err), 1);

        // 6: START_WAIT t0, tim_ready drops mid-WAIT, then async reset
        send(OP_START_WAIT, 2'd0, 3'd3);
        check("t6_ld", 32'(timer_ld), 32'h1);
        tick();
        check("t6_wait", 32'(busy), 1);
        tim_ready = 1'b0;
        tick();
        tick();
        check("t6_hold_busy",  32'(busy), 1);
        check("t6_hold_ready", 32'(cmd_if.cmd_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("t6_ld0",    32'(timer_ld), 0);
        check("t6_sel0",   32'(timer_sel), 0);
        check("t6_adr0",   32'(timer_mem_adr), 0);
        check("t6_flags0", 32'(done_flags), 0);
        check("t6_busy0",  32'(busy), 0);
        check("t6_err0",   32'(err), 0);
        check("t6_ready0", 32'(cmd_if.cmd_ready), 0);
        #2 rst = 1'b0;
        #1;
        check("t6_tr_low",  32'(cmd_if.cmd_ready), 0);
        tim_ready = 1'b1;
        #1;
        check("t6_tr_high", 32'(cmd_if.cmd_ready), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
